// File: rtl/cla8_seq_adder.sv
// Byte-serial wide adder: one 8-bit carry-lookahead slice, LSB first, chained through a carry flop.
// Defining CLA_SEQ_SUB_EN adds a `sub` input that turns the operation into A-B.
module cla8_seq_adder #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic                  sub,
`endif
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  busy
);

    localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q, state_d;
    logic [NBYTES-1:0][7:0]  a_q, a_d;
    logic [NBYTES-1:0][7:0]  b_q, b_d;
    logic [NBYTES-1:0][7:0]  sum_q, sum_d;
    logic                    carry_q, carry_d;
    logic                    cout_q, cout_d;
    logic [IdxW-1:0]         idx_q, idx_d;
`ifdef CLA_SEQ_SUB_EN
    logic                    sub_q, sub_d;
`endif

    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic [8:0] slice;

    // Every carry is a flat sum-of-products of generate/propagate terms, not a ripple.
    function automatic logic [8:0] cla8(input logic [7:0] x, input logic [7:0] y,
                                        input logic ci);
        logic [7:0] g;
        logic [7:0] p;
        logic [8:0] c;
        logic       prod;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < 8; i++) begin
            prod     = 1'b1;
            c[i + 1] = 1'b0;
            for (int j = i; j >= 0; j--) begin
                c[i + 1] = c[i + 1] | (g[j] & prod);
                prod     = prod & p[j];
            end
            c[i + 1] = c[i + 1] | (prod & ci);
        end
        return {c[8], p ^ c[7:0]};
    endfunction

    always_comb begin
        a_byte = a_q[idx_q];
        b_byte = b_q[idx_q];
`ifdef CLA_SEQ_SUB_EN
        b_byte = b_byte ^ {8{sub_q}};
`endif
        slice = cla8(a_byte, b_byte, carry_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef CLA_SEQ_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    a_d   = a;
                    b_d   = b;
                    sum_d = '0;
                    idx_d = '0;
`ifdef CLA_SEQ_SUB_EN
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
`else
                    carry_d = cin;
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[idx_q] = slice[7:0];
                carry_d      = slice[8];
                if (idx_q == LastIdx) begin
                    cout_d  = slice[8];
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef CLA_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef CLA_SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign start_ready = (state_q == StIdle);
    assign res_valid   = (state_q == StDone);
    assign busy        = (state_q != StIdle);
    assign sum         = sum_q;
    assign cout        = cout_q;

endmodule

// File: tb/tb_cla8_seq_adder.sv
// Scoreboard bench for cla8_seq_adder: driver pushes expected results, monitor pops on consume.
module tb_cla8_seq_adder;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef CLA_SEQ_SUB_EN
    logic         sub_sel = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } res_t;

    res_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    cla8_seq_adder #(.NBYTES(NB)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub         (sub_sel),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a result is taken on the edge after a cycle with res_valid && res_ready.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                check("sb_expected_present", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_sum", sum, e.s);
                    check("sb_cout", cout, e.c);
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          input logic [W-1:0] es, input logic ec,
                          input bit scramble, input bit hold, input bit early);
        res_ready   = early;
        a           = av;
        b           = bv;
        cin         = ci;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        if (scramble) begin
            a   = '0;
            b   = '0;
            cin = 1'b0;
        end
        exp_q.push_back(res_t'{s: es, c: ec});
        check("busy_after_accept", busy, 1);
        check("ready_low_in_run", start_ready, 0);
        for (int k = 1; k < NB; k++) begin
            tick();
            if (k == NB - 1) check("valid_not_early", res_valid, 0);
        end
        tick();
        check("latency_valid", res_valid, 1);
        check("done_sum", sum, es);
        check("done_cout", cout, ec);
        if (hold) begin
            for (int k = 0; k < 5; k++) begin
                start_valid = ~start_valid;
                tick();
                check("hold_valid", res_valid, 1);
                check("hold_sum", sum, es);
                check("hold_cout", cout, ec);
                check("hold_start_ready", start_ready, 0);
            end
            start_valid = 1'b0;
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("consumed_valid", res_valid, 0);
        check("consumed_start_ready", start_ready, 1);
        check("consumed_busy", busy, 0);
        check("held_sum_after", sum, es);
    endtask

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        res_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_start_ready", start_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);

        run_op(32'h0000_00FA, 32'h0000_00F0, 1'b0, 32'h0000_01EA, 1'b0, 0, 0, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 0, 0, 0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1, 0, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 0, 1, 0);

        // Reset together with a request: reset wins.
        rst         = 1'b1;
        start_valid = 1'b1;
        a           = 32'h1;
        b           = 32'h1;
        tick();
        rst         = 1'b0;
        start_valid = 1'b0;
        check("rst_wins_busy", busy, 0);
        check("rst_wins_start_ready", start_ready, 1);

        // Abort after two RUN edges; partial sum and stale cout must be wiped.
        a           = 32'h0102_0304;
        b           = 32'h1020_3040;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_start_ready", start_ready, 1);
        check("abort_res_valid", res_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);

        run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 0, 0, 0);
        run_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 32'hEFBE_D000, 1'b0, 0, 0, 1);

`ifdef CLA_SEQ_SUB_EN
        sub_sel = 1'b1;
        run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 0, 0, 0);
        run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 0, 0, 0);
        sub_sel = 1'b0;
        run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_000D, 1'b0, 0, 0, 0);
`endif

        tick();
        tick();
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
